mult4_arbiter: RTL and testbench

- Shares one combinational 4x4 unsigned array multiplier among N_REQ requesters.
- Each requester presents an operand pair through a valid/ready handshake.
- A round-robin arbiter admits one pair per cycle; the full 8-bit product is registered with the winning requester's ID.
- The result leaves on a single valid/ready output channel with backpressure, between requester logic and downstream consumers.

---
 rtl/mult4_arb_pkg.sv | 23 ++
 rtl/array_mul4.sv | 41 ++++
 rtl/mult4_arbiter.sv | 107 ++++++++++
 tb/tb_mult4_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mult4_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mult4_arb_pkg : shared widths and ID-width helper for mult4_arb |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
package mult4_arb_pkg;

  localparam int OP_W      = 4;
  localparam int PROD_W    = 8;
  localparam int N_REQ_MAX = 8;

  // Minimum index width for n requesters (at least one bit).
  function automatic int id_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage : mult4_arb_pkg
`default_nettype wire

// File: rtl/array_mul4.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | array_mul4 : combinational 4x4 unsigned array multiplier         |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module array_mul4
  import mult4_arb_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product
);

  logic [OP_W-1:0] w_pp  [OP_W];
  logic [OP_W-1:0] w_acc [OP_W];

  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign w_pp[i] = a & {OP_W{b[i]}};
  end

  // w_acc[i] holds the running sum above the product bits already retired.
  assign w_acc[0]   = {1'b0, w_pp[0][OP_W-1:1]};
  assign product[0] = w_pp[0][0];

  for (genvar i = 1; i < OP_W; i++) begin : g_row
    logic [OP_W:0]   w_c;
    logic [OP_W-1:0] w_s;
    assign w_c[0] = 1'b0;
    for (genvar j = 0; j < OP_W; j++) begin : g_fa
      assign w_s[j]   = w_acc[i-1][j] ^ w_pp[i][j] ^ w_c[j];
      assign w_c[j+1] = (w_acc[i-1][j] & w_pp[i][j]) |
                        (w_c[j] & (w_acc[i-1][j] ^ w_pp[i][j]));
    end
    assign w_acc[i]   = {w_c[OP_W], w_s[OP_W-1:1]};
    assign product[i] = w_s[0];
  end

  assign product[PROD_W-1:OP_W] = w_acc[OP_W-1];

endmodule : array_mul4
`default_nettype wire

// File: rtl/mult4_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mult4_arbiter : round-robin shared 4x4 multiplier, 1-deep output |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module mult4_arbiter
  import mult4_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [OP_W*N_REQ-1:0] req_a,
  input  logic [OP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  out_valid,
  output logic [PROD_W-1:0]     out_product,
  output logic [ID_W-1:0]       out_id,
  input  logic                  out_ready
);

  if (ID_W != id_width(N_REQ) || N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_param_check
    $error("mult4_arbiter: inconsistent N_REQ / ID_W");
  end

  localparam logic [ID_W:0]   c_n_req = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] c_last  = ID_W'(N_REQ - 1);

  logic              w_accept;
  logic              w_any;
  logic [N_REQ-1:0]  w_rot;
  logic [ID_W-1:0]   w_off;
  logic [ID_W:0]     w_sum;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [OP_W-1:0]   w_a;
  logic [OP_W-1:0]   w_b;
  logic [PROD_W-1:0] w_prod;

  logic              r_valid;
  logic [PROD_W-1:0] r_product;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_ptr;

  assign w_accept = !r_valid || out_ready;
  assign w_any    = |req_valid;

  // Rotate so bit 0 is the requester at r_ptr; the first set bit is the offset.
  assign w_rot = N_REQ'({req_valid, req_valid} >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = ID_W'(k);
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win     = (w_sum >= c_n_req) ? ID_W'(w_sum - c_n_req) : ID_W'(w_sum);
  assign w_ptr_nxt = (w_win == c_last) ? '0 : w_win + 1'b1;

  assign req_ready = (w_accept && w_any && !rst) ? (N_REQ'(1) << w_win) : '0;

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_a = req_a[OP_W*i +: OP_W];
        w_b = req_b[OP_W*i +: OP_W];
      end
    end
  end

  array_mul4 u_mul (
    .a       (w_a),
    .b       (w_b),
    .product (w_prod)
  );

  // The output register is the only pipeline stage; product/id hold on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_product <= '0;
      r_id      <= '0;
      r_ptr     <= '0;
    end else if (w_accept) begin
      if (w_any) begin
        r_valid   <= 1'b1;
        r_product <= w_prod;
        r_id      <= w_win;
        r_ptr     <= w_ptr_nxt;
      end else begin
        r_valid   <= 1'b0;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_product = r_product;
  assign out_id      = r_id;

endmodule : mult4_arbiter
`default_nettype wire

// File: tb/tb_mult4_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_mult4_arbiter : directed scoreboard bench for mult4_arbiter   |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module tb_mult4_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_product;
  logic [1:0]  out_id;
  logic        out_ready;

  int n_vec;
  int n_fail;
  logic [9:0] exp_q[$];

  mult4_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_product (out_product),
    .out_id      (out_id),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
  endtask

  task automatic push(input int id, input int prod);
    exp_q.push_back({2'(id), 8'(prod)});
  endtask

  // Monitor: a result is consumed at the next rising edge when valid && ready.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_result: got id=%0d product=%0d, expected none", out_id, out_product);
        end else begin
          e = exp_q.pop_front();
          chk("sb_product", int'(out_product), int'(e[7:0]));
          chk("sb_id", int'(out_id), int'(e[9:8]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'd3);

    // Reset held for three edges with all requesters valid
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_out_id", int'(out_id), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Round robin: 0,1,2,3,0 with products 3,6,9,12,3
    push(0, 3); push(1, 6); push(2, 9); push(3, 12); push(0, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_ready", int'(req_ready), 1 << (k % 4));
      if (k > 0) chk("rr_no_bubble", int'(out_valid), 1);
    end
    step();
    req_valid = 4'b0000;

    // Drain: last result presented, then valid falls with data held
    @(negedge clk);
    chk("drain_valid_pre", int'(out_valid), 1);
    @(negedge clk);
    chk("drain_valid", int'(out_valid), 0);
    chk("drain_hold_product", int'(out_product), 3);
    chk("drain_hold_id", int'(out_id), 0);

    // Single request: 15*15
    step();
    set_op(2, 4'd15, 4'd15);
    req_valid = 4'b0100;
    push(2, 225);
    @(negedge clk);
    chk("single_ready", int'(req_ready), 4'b0100);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single_ready_off", int'(req_ready), 0);
    @(negedge clk);
    chk("single_drain", int'(out_valid), 0);

    // Idle cycles keep the pointer at 3
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'b1011;
    push(3, 12);
    @(negedge clk);
    chk("idle_ptr_ready", int'(req_ready), 4'b1000);
    step();
    req_valid = 4'b0000;
    @(negedge clk);

    // Backpressure: 9*7 held while requester 3 waits
    step();
    set_op(1, 4'd9, 4'd7);
    req_valid = 4'b0010;
    push(1, 63);
    @(negedge clk);
    chk("bp_first_ready", int'(req_ready), 4'b0010);
    step();
    set_op(3, 4'd11, 4'd13);
    req_valid = 4'b1000;
    push(3, 143);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_product", int'(out_product), 63);
      chk("bp_id", int'(out_id), 1);
      chk("bp_ready", int'(req_ready), 0);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", int'(req_ready), 4'b1000);
    step();
    req_valid = 4'b0000;
    @(negedge clk);

    // Async reset with a held result and the pointer at 3
    step();
    set_op(2, 4'd6, 4'd7);
    req_valid = 4'b0100;
    out_ready = 1'b0;
    @(negedge clk);
    chk("ar_grant2", int'(req_ready), 4'b0100);
    step();
    chk("ar_pending", int'(out_valid), 1);
    set_op(0, 4'd0, 4'd13);
    req_valid = 4'b1001;
    #1;
    rst = 1'b1;
    #1;
    chk("ar_valid_async", int'(out_valid), 0);
    chk("ar_ready_in_rst", int'(req_ready), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    push(0, 0);
    @(negedge clk);
    chk("ar_restart_ready", int'(req_ready), 4'b0001);
    step();
    req_valid = 4'b0000;

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending results, expected 0", exp_q.size());
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_mult4_arbiter
`default_nettype wire
